pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised next-generation fetch-PC unit for the RISC-V core.
- Owns the architectural PC register. Computes the next PC from the decode-stage npc_op selection.
- Adds stall hold, later-stage redirect, trap vectoring, target-misalignment detection and a boot state.
- Sits between the instruction-fetch address port and the decode/execute stages. Optionally tracks calls/returns in a return-address stack.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned target.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2); used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc_op  in  2  next-PC select: PLUS_4 / BRANCH_CHOOSE / JUMP_REG / JUMP.
- imm  in  XLEN  sign-extended immediate in halfword units.
- branch  in  1  B-type condition true.
- rs1  in  XLEN  jalr source operand.
- stall  in  1  hold current PC.
- redirect_valid  in  1  later stage forces the PC.
- redirect_pc  in  XLEN  forced target.
- trap  in  1  exception or ecall request.
- is_call  in  1  current jal/jalr writes the link register.
- is_ret  in  1  current jalr is a return.
- pc  out  XLEN  registered fetch PC.
- pc_plus4  out  XLEN  pc+4, combinational from pc.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- misalign  out  1  registered one-cycle pulse: computed target had bit[1:0] != 0.
- ras_hit  out  1  registered; RAS-predicted return equalled the computed jalr target.

Behaviour:
- Reset (async assert):
  - pc=RESET_VEC, fetch_valid=0, misalign=0, ras_hit=0, state=BOOT, RAS pointer/count=0.
- States:
  - BOOT: one cycle after rst_n deasserts; pc unchanged, then go to RUN with fetch_valid=1.
  - RUN: pc advances each cycle.
  - STALL: entered when stall=1 in RUN; pc held, fetch_valid=1. Returns to RUN in the cycle stall=0.
- Target computation, XLEN-bit, wraps modulo 2^XLEN:
  - PLUS_4: pc+4.
  - BRANCH_CHOOSE: branch ? pc+(imm<<1) : pc+4.
  - JUMP: pc+(imm<<1).
  - JUMP_REG: (rs1+imm) with bit0 cleared.
- Priority each cycle, highest first:
  1. trap → pc=TRAP_VEC.
  2. redirect_valid → pc=redirect_pc.
  3. stall → hold pc.
  4. Computed target.
- redirect or trap while in STALL: takes effect immediately; next state RUN.
- Misalignment: if the computed target (not trap or redirect) has [1:0]!=0, pc=TRAP_VEC next cycle and misalign=1 for that cycle.
- Wrap-around: pc=XLEN'hFFFF_FFFC with PLUS_4 → pc=0. No special-casing; natural wrap.
- npc_op values outside the defined set are impossible with 2-bit encoding; every code is defined.
- Latency: pc updates one clock after the inputs are sampled. pc_plus4 and target logic are combinational.

Optional Feature:
- Macro PC_GEN_RAS_EN.
- With the macro, a RAS_DEPTH circular stack is instantiated:
  - Push: a non-stalled JUMP or JUMP_REG with is_call=1 pushes pc+4.
  - Pop: a non-stalled JUMP_REG with is_ret=1 pops; ras_hit=1 next cycle if the popped value equals the computed target, else 0.
  - Call and ret together: pop first, then push.
  - Pop when empty: no pop, ras_hit=0.
  - Push when full: overwrites the oldest entry; count saturates.
  - trap or redirect cycles perform no push or pop.
  - pc selection is never changed by the RAS.
- Without the macro: no stack storage; is_call/is_ret ignored; ras_hit tied 0.

Decomposition:
- Shared param.v include holds the npc_op encodings:
  - PLUS_4=2'b00
  - BRANCH_CHOOSE=2'b01
  - JUMP_REG=2'b10
  - JUMP=2'b11
- Shared param.v also holds the state encodings BOOT/RUN/STALL.
- One sub-module, pc_gen_ras: the stack, with push/pop/data/hit ports, compiled only under PC_GEN_RAS_EN.

Test Plan:
- Reset release, npc_op=PLUS_4 → pc=0 in the BOOT cycle, fetch_valid=0. Then pc=0, 4, 8 with fetch_valid=1.
- pc=0x40, BRANCH_CHOOSE, imm=8: branch=1 → pc=0x50; branch=0 → pc=0x44. pc=0xFFFF_FFFC with PLUS_4 → pc=0.
- Misaligned jalr: rs1=0x1002, imm=0 → pc=TRAP_VEC=0x100 next cycle, misalign pulses exactly one cycle.
- stall held 3 cycles at pc=0x20 → pc stays 0x20. redirect_valid=1, redirect_pc=0x300 in the 2nd stall cycle → pc=0x300. trap and redirect together → pc=0x100.
- With PC_GEN_RAS_EN: call at pc=0x10 pushes 0x14; ret with rs1=0x14 → ras_hit=1. Ret on empty stack → ras_hit=0. Five calls with depth 4, then four rets → last three pushed addresses hit, in LIFO order.
- Async reset mid-STALL with a populated RAS → pc=0, state BOOT, stack empty, all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/pc_gen_unit_pkg.sv
// Shared encodings for the fetch-PC unit: next-PC select codes and control states.
// Optional return-address stack is enabled with `define PC_GEN_RAS_EN.
package pc_gen_unit_pkg;

  typedef enum logic [1:0] {
    PLUS_4        = 2'b00,
    BRANCH_CHOOSE = 2'b01,
    JUMP_REG      = 2'b10,
    JUMP          = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } pc_state_e;

  // Instruction fetch addresses must be word aligned.
  function automatic logic word_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack used for call/return prediction checking.
// Compiled only when PC_GEN_RAS_EN is defined.
`ifdef PC_GEN_RAS_EN
module pc_gen_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  input  logic [XLEN-1:0] cmp_target,
  output logic            hit
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stack_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;
  logic [XLEN-1:0]  top_data;
  logic             hit_q;

  assign top_idx  = ptr_q - PTR_W'(1);
  assign pop_ok   = pop && (cnt_q != '0);
  assign top_data = stack_mem[top_idx];
  assign hit      = hit_q;

  // A simultaneous pop and push replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[pop_ok ? top_idx : ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= pop_ok && (top_data == cmp_target);
      if (pop_ok && !push) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (push && !pop_ok) begin
        ptr_q <= ptr_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: owns the architectural PC, applies trap/redirect/stall priority.
// Define PC_GEN_RAS_EN to add the return-address stack (ras_hit otherwise tied low).
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      npc_op,
  input  logic [XLEN-1:0] imm,
  input  logic            branch,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            misalign,
  output logic            ras_hit
);

  pc_state_e       state_q, state_d;
  npc_op_e         op_sel;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic            take_target;

  assign op_sel      = npc_op_e'(npc_op);
  assign pc_plus4    = pc_q + XLEN'(4);
  assign branch_tgt  = pc_q + (imm << 1);
  assign jalr_tgt    = (rs1 + imm) & ~(XLEN'(1));
  assign pc          = pc_q;
  assign misalign    = misalign_q;
  assign fetch_valid = (state_q != BOOT);

  always_comb begin
    target = pc_plus4;
    case (op_sel)
      PLUS_4:        target = pc_plus4;
      BRANCH_CHOOSE: target = branch ? branch_tgt : pc_plus4;
      JUMP_REG:      target = jalr_tgt;
      JUMP:          target = branch_tgt;
      default:       target = pc_plus4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    take_target = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      default: begin
        if (trap) begin
          pc_d    = TRAP_VEC;
          state_d = RUN;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          take_target = 1'b1;
          state_d     = RUN;
          if (word_misaligned(target[1:0])) begin
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
          end else begin
            pc_d = target;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_GEN_RAS_EN
  logic ras_push, ras_pop;

  assign ras_push = take_target && is_call && (op_sel == JUMP || op_sel == JUMP_REG);
  assign ras_pop  = take_target && is_ret && (op_sel == JUMP_REG);

  pc_gen_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ras_push),
    .pop        (ras_pop),
    .push_data  (pc_plus4),
    .cmp_target (jalr_tgt),
    .hit        (ras_hit)
  );
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_ras_inputs;

  assign unused_ras_inputs = is_call | is_ret | take_target;
  assign ras_hit           = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: vector table for PC sequencing, hand sequences for RAS and reset.
module tb_pc_gen_unit;

  localparam logic [1:0] OP_P4 = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_JR = 2'b10;
  localparam logic [1:0] OP_J  = 2'b11;

`ifdef PC_GEN_RAS_EN
  localparam logic RAS_ON = 1'b1;
`else
  localparam logic RAS_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] imm;
    logic        br;
    logic [31:0] rs1;
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    logic        tr;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  npc_op;
  logic [31:0] imm;
  logic        branch;
  logic [31:0] rs1;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic        is_call;
  logic        is_ret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign;
  logic        ras_hit;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_gen_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100),
    .RAS_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .npc_op         (npc_op),
    .imm            (imm),
    .branch         (branch),
    .rs1            (rs1),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap           (trap),
    .is_call        (is_call),
    .is_ret         (is_ret),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .misalign       (misalign),
    .ras_hit        (ras_hit)
  );

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] im, input logic b,
                              input logic [31:0] r1, input logic st, input logic rv,
                              input logic [31:0] rp, input logic tr, input logic [31:0] epc,
                              input logic emis);
    vec_t v;
    v.op = op; v.imm = im; v.br = b; v.rs1 = r1; v.stl = st; v.rv = rv;
    v.rpc = rp; v.tr = tr; v.exp_pc = epc; v.exp_mis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] im, input logic b,
                       input logic [31:0] r1, input logic st, input logic rv,
                       input logic [31:0] rp, input logic tr, input logic cl, input logic rt);
    npc_op = op; imm = im; branch = b; rs1 = r1; stall = st;
    redirect_valid = rv; redirect_pc = rp; trap = tr; is_call = cl; is_ret = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] target);
    drive(OP_P4, 0, 0, 0, 0, 1, target, 0, 0, 0);
    chk("redir_pc", pc, target);
  endtask

  task automatic call_j(input logic [31:0] exp_pc);
    drive(OP_J, 32'h8, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("call_pc", pc, exp_pc);
  endtask

  task automatic ret_jr(input string name, input logic [31:0] r1, input logic exp_hit);
    drive(OP_JR, 0, 0, r1, 0, 0, 0, 0, 0, 1);
    chk({name, "_pc"}, pc, r1);
    chk({name, "_hit"}, ras_hit, exp_hit);
  endtask

  initial begin
    logic [31:0] ret_addr [4];
    logic        ret_hit  [4];

    rst_n = 1'b0;
    npc_op = OP_P4; imm = '0; branch = 1'b0; rs1 = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; trap = 1'b0; is_call = 1'b0; is_ret = 1'b0;

    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h0,        0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h4,        0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h8,        0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 1, 32'h40,       0, 32'h40,       0));
    vecs.push_back(mk(OP_BR, 32'h8,       1, 0,          0, 0, 0,            0, 32'h50,       0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 1, 32'h40,       0, 32'h40,       0));
    vecs.push_back(mk(OP_BR, 32'h8,       0, 0,          0, 0, 0,            0, 32'h44,       0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h0,        0));
    vecs.push_back(mk(OP_J,  32'h10,      0, 0,          0, 0, 0,            0, 32'h20,       0));
    vecs.push_back(mk(OP_J,  32'h40,      0, 0,          1, 0, 0,            0, 32'h20,       0));
    vecs.push_back(mk(OP_J,  32'h40,      0, 0,          1, 0, 0,            0, 32'h20,       0));
    vecs.push_back(mk(OP_J,  32'h40,      0, 0,          1, 0, 0,            0, 32'h20,       0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h24,       0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          1, 0, 0,            0, 32'h24,       0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          1, 1, 32'h300,      0, 32'h300,      0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 1, 32'h500,      1, 32'h100,      0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h104,      0));
    vecs.push_back(mk(OP_JR, 0,           0, 32'h1002,   0, 0, 0,            0, 32'h100,      1));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h104,      0));
    vecs.push_back(mk(OP_JR, 32'h3,       0, 32'h2001,   0, 0, 0,            0, 32'h2004,     0));
    vecs.push_back(mk(OP_J,  32'hFFFFFFFC, 0, 0,         0, 0, 0,            0, 32'h1FFC,     0));
    vecs.push_back(mk(OP_J,  32'h1,       0, 0,          0, 0, 0,            0, 32'h100,      1));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h104,      0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          1, 0, 0,            0, 32'h104,      0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          1, 0, 0,            1, 32'h100,      0));
    vecs.push_back(mk(OP_P4, 0,           0, 0,          0, 0, 0,            0, 32'h104,      0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", fetch_valid, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_hit", ras_hit, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_pc", pc, 32'h0);
    chk("boot_fv", fetch_valid, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].imm, vecs[i].br, vecs[i].rs1, vecs[i].stl,
            vecs[i].rv, vecs[i].rpc, vecs[i].tr, 1'b0, 1'b0);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_mis", i), misalign, vecs[i].exp_mis);
      chk($sformatf("v%0d_fv", i), fetch_valid, 1'b1);
      chk($sformatf("v%0d_hit", i), ras_hit, 1'b0);
    end

    // Single call/return, then return with nothing stacked.
    redir(32'h10);
    call_j(32'h20);
    chk("call1_hit", ras_hit, 1'b0);
    ret_jr("ret1", 32'h14, RAS_ON);
    drive(OP_P4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_ret_hit", ras_hit, 1'b0);
    ret_jr("ret_empty", 32'h14, 1'b0);

    // Overflow: five calls into four entries; the oldest push is lost.
    redir(32'h10);
    for (int k = 0; k < 5; k++) begin
      call_j(32'h20 + 32'h10 * k);
    end
    ret_addr[0] = 32'h54; ret_hit[0] = RAS_ON;
    ret_addr[1] = 32'h44; ret_hit[1] = RAS_ON;
    ret_addr[2] = 32'h34; ret_hit[2] = RAS_ON;
    ret_addr[3] = 32'h14; ret_hit[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ret_jr($sformatf("ovf_ret%0d", k), ret_addr[k], ret_hit[k]);
    end
    ret_jr("ovf_ret_empty", 32'h54, 1'b0);

    // Combined call+ret pops then pushes; trap cycles leave the stack alone.
    redir(32'h10);
    call_j(32'h20);
    drive(OP_JR, 0, 0, 32'h14, 0, 0, 0, 0, 1, 1);
    chk("cr_pc", pc, 32'h14);
    chk("cr_hit", ras_hit, RAS_ON);
    drive(OP_JR, 0, 0, 32'h24, 0, 0, 0, 1, 0, 1);
    chk("trap_ret_pc", pc, 32'h100);
    chk("trap_ret_hit", ras_hit, 1'b0);
    ret_jr("cr_ret", 32'h24, RAS_ON);
    ret_jr("cr_ret_empty", 32'h24, 1'b0);

    // Asynchronous reset while stalled with entries on the stack.
    redir(32'h10);
    call_j(32'h20);
    call_j(32'h30);
    call_j(32'h40);
    ret_jr("pre_rst_ret", 32'h34, RAS_ON);
    drive(OP_P4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("stall_pc", pc, 32'h34);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_fv", fetch_valid, 1'b0);
    chk("arst_mis", misalign, 1'b0);
    chk("arst_hit", ras_hit, 1'b0);
    drive(OP_P4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reboot_pc", pc, 32'h0);
    chk("reboot_fv", fetch_valid, 1'b0);
    drive(OP_P4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reboot_run_pc", pc, 32'h0);
    chk("reboot_run_fv", fetch_valid, 1'b1);
    ret_jr("post_rst_ret", 32'h24, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
